frac_ce_gen: RTL and testbench
==============================

Name: frac_ce_gen

Overview:
Parametrised, multi-channel successor to the fixed single-output clock wrapper. It generates NUM_CH clock-enable streams from one reference clock. Each channel averages exactly refclk*num/den using a fractional phase accumulator. Ratios are reprogrammable at run time through a valid/ready handshake. A locked indication drops while a new ratio settles. It sits beside the system PLL and feeds ce_p/ce_n to cores that need non-integer rates, such as 14.31818 MHz-derived CPU and video enables.

Parameters:
NUM_CH, 4, number of enable channels (1..16)
ACC_W, 16, width of num, den and accumulator
LOCK_CYCLES, 16, settle cycles after reset or an accepted reconfig before locked reasserts (>=1)
DEF_NUM, {NUM_CH{16'd1}}, packed NUM_CH*ACC_W reset numerators
DEF_DEN, {NUM_CH{16'd1}}, packed NUM_CH*ACC_W reset denominators

Ports:
refclk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
sync  in  1  clears all accumulators (phase-align all channels)
cfg_valid  in  1  config request
cfg_ready  out  1  config accept (transfer = valid & ready)
cfg_ch  in  CHW=max(1,$clog2(NUM_CH))  target channel
cfg_num  in  ACC_W  new numerator
cfg_den  in  ACC_W  new denominator
cfg_err  out  1  one-cycle pulse: request rejected
ce_p  out  NUM_CH  rising-phase enable pulses, registered
ce_n  out  NUM_CH  mid-period enable pulses (FRAC_CE_HALF_EN only)
locked  out  1  all ratios stable

Behaviour:
- Reset (async assert, sync release):
  - ce_p, ce_n, cfg_err = 0; locked = 0; cfg_ready = 0.
  - num/den load from DEF_NUM/DEF_DEN; all accumulators = 0; FSM = SETTLE with counter = 0.
- Channel arithmetic, per edge, when channel enabled (num != 0) and sync = 0:
  - nxt = acc + num, computed at ACC_W+1 bits.
  - ce_p_q <= (nxt >= den).
  - acc <= (nxt >= den) ? nxt - den : nxt.
- Invariant: acc < den always holds.
- Latency: ce_p is high for the cycle after the edge on which the wrap is computed.
- num = 0: channel disabled; ce_p/ce_n stay 0 and acc holds.
- num = den: ce_p is asserted continuously.
- sync = 1: all acc <= 0 and all ce outputs <= 0 that edge. sync takes priority over counting and over APPLY's clear.
- Config FSM:
  - IDLE: cfg_ready = 1. On transfer, capture the request and go to APPLY.
  - APPLY (1 cycle, cfg_ready = 0): validate the request.
    - Reject if cfg_den = 0, cfg_num > cfg_den, or cfg_ch >= NUM_CH.
    - Rejected: cfg_err = 1 for one cycle, no state changes, next state IDLE, locked unaffected.
    - Accepted: write num/den for that channel, clear its acc and ce, locked <= 0, next state SETTLE.
  - SETTLE: cfg_ready = 0; counter increments each cycle. At count = LOCK_CYCLES-1: locked <= 1, counter cleared, next state IDLE.
- Other channels keep counting uninterrupted during APPLY and SETTLE. Only the target channel restarts.
- Holding cfg_valid while cfg_ready = 0 is legal. The request stalls and must hold stable (AXI-style).
- Reset mid-SETTLE: locked = 0 immediately and the settle count restarts from 0 after release.
- locked first rises LOCK_CYCLES cycles after reset release.

Optional Feature:
Macro FRAC_CE_HALF_EN.
- With the macro:
  - h = den >> 1.
  - ce_n_q <= (acc < h) && (nxt >= h) && !(nxt >= den) on counting edges. This gives one ce_n roughly midway between consecutive ce_p pulses.
  - Valid only when num <= h; otherwise ce_n = 0. That condition is a documented constraint, not a reject.
  - sync and reset clear ce_n.
- Without the macro: the ce_n port is omitted entirely and no half-point comparators are synthesised.

Decomposition:
- Package frac_ce_pkg:
  - FSM state enum (IDLE, APPLY, SETTLE).
  - CHW derivation function.
  - Default ACC_W/LOCK_CYCLES constants.
- Sub-module frac_ce_chan, instantiated NUM_CH times:
  - Holds num/den/acc registers, wrap logic, optional ce_n.
  - Inputs: load strobe, clear, sync.
- Top level holds the FSM, the settle counter and request validation.

Test Plan:
1. Reset release, defaults 1/1 -> locked rises exactly 16 cycles after rst_n high; ce_p[3:0] = 4'hF every cycle from the first counting edge.
2. Config ch0 num=1 den=4, then sync -> ce_p[0] visible after 4th, 8th, 12th edges post-sync; other channels unaffected; locked low for 16 cycles after APPLY.
3. ch1 num=358 den=1250 (≈14.31818/50) -> exactly 358 ce_p[1] pulses in every 1250-cycle window after sync; no two pulses adjacent.
4. Rejects: num=5 den=4; den=0; cfg_ch=4 with NUM_CH=4 -> cfg_err one-cycle pulse each; locked stays 1; ratios unchanged.
5. cfg_valid held during SETTLE -> cfg_ready = 0, request accepted on first IDLE cycle; sync asserted in an APPLY cycle -> all acc = 0 and no ce that edge.
6. FRAC_CE_HALF_EN, num=1 den=8 -> ce_p every 8 cycles, ce_n exactly 4 cycles after each ce_p; async rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/frac_ce_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// FRAC_CE_HALF_EN adds the mid-period ce_n outputs.
package frac_ce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE
    } cfg_state_e;

    localparam int DEF_ACC_W       = 16;
    localparam int DEF_LOCK_CYCLES = 16;

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frac_ce_gen_chan.sv
// One fractional enable channel: phase accumulator, wrap detect and optional
// half-point enable (FRAC_CE_HALF_EN).
module frac_ce_chan
    import frac_ce_pkg::*;
#(
    parameter int               ACC_W   = DEF_ACC_W,
    parameter logic [ACC_W-1:0] RST_NUM = ACC_W'(1),
    parameter logic [ACC_W-1:0] RST_DEN = ACC_W'(1)
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             sync,
    input  logic             load,
    input  logic [ACC_W-1:0] ld_num,
    input  logic [ACC_W-1:0] ld_den,
`ifdef FRAC_CE_HALF_EN
    output logic             ce_n,
`endif
    output logic             ce_p
);

    logic [ACC_W-1:0] num_q, num_d, den_q, den_d, acc_q, acc_d;
    logic             ce_p_q, ce_p_d;
    logic [ACC_W:0]   nxt, rem;
    logic             wrap, count;

    always_comb begin
        nxt    = {1'b0, acc_q} + {1'b0, num_q};
        rem    = nxt - {1'b0, den_q};
        wrap   = nxt >= {1'b0, den_q};
        count  = !sync && !load && (num_q != '0);
        num_d  = num_q;
        den_d  = den_q;
        acc_d  = acc_q;
        ce_p_d = 1'b0;
        if (load) begin
            num_d = ld_num;
            den_d = ld_den;
            acc_d = '0;
        end else if (count) begin
            ce_p_d = wrap;
            acc_d  = wrap ? rem[ACC_W-1:0] : nxt[ACC_W-1:0];
        end
        // sync wins over both counting and a reload's clear
        if (sync) acc_d = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            num_q  <= RST_NUM;
            den_q  <= RST_DEN;
            acc_q  <= '0;
            ce_p_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            den_q  <= den_d;
            acc_q  <= acc_d;
            ce_p_q <= ce_p_d;
        end
    end

    assign ce_p = ce_p_q;

`ifdef FRAC_CE_HALF_EN
    logic [ACC_W-1:0] h;
    logic             ce_n_q, ce_n_d;

    // Only meaningful while num <= den/2; larger ratios leave ce_n quiet.
    always_comb begin
        h      = den_q >> 1;
        ce_n_d = count && (num_q <= h) && (acc_q < h) && (nxt >= {1'b0, h}) && !wrap;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) ce_n_q <= 1'b0;
        else        ce_n_q <= ce_n_d;
    end

    assign ce_n = ce_n_q;
`endif

endmodule

// File: rtl/frac_ce_gen.sv
// Multi-channel fractional clock-enable generator with handshake reconfig.
// Define FRAC_CE_HALF_EN to get the ce_n mid-period enables.
module frac_ce_gen
    import frac_ce_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      ACC_W       = DEF_ACC_W,
    parameter int                      LOCK_CYCLES = DEF_LOCK_CYCLES,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM     = {NUM_CH{ACC_W'(1)}},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN     = {NUM_CH{ACC_W'(1)}},
    localparam int                     CHW         = chw(NUM_CH)
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]  cfg_num,
    input  logic [ACC_W-1:0]  cfg_den,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] ce_p,
`ifdef FRAC_CE_HALF_EN
    output logic [NUM_CH-1:0] ce_n,
`endif
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES) + 1;

    typedef struct packed {
        logic [CHW-1:0]   ch;
        logic [ACC_W-1:0] num;
        logic [ACC_W-1:0] den;
    } cfg_req_t;

    cfg_state_e        state_q, state_d;
    cfg_req_t          req_q, req_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q, locked_d;
    logic              req_ok;
    logic [NUM_CH-1:0] load;

    assign req_ok = (req_q.den != '0) && (req_q.num <= req_q.den) && (int'(req_q.ch) < NUM_CH);

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_SETTLE;
            req_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cnt_d    = cnt_q;
        locked_d = locked_q;
        case (state_q)
            ST_IDLE: if (cfg_valid) begin
                req_d.ch  = cfg_ch;
                req_d.num = cfg_num;
                req_d.den = cfg_den;
                state_d   = ST_APPLY;
            end
            ST_APPLY: if (req_ok) begin
                locked_d = 1'b0;
                cnt_d    = '0;
                state_d  = ST_SETTLE;
            end else begin
                state_d  = ST_IDLE;
            end
            ST_SETTLE: if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                locked_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end else begin
                cnt_d    = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == ST_IDLE);
        cfg_err   = (state_q == ST_APPLY) && !req_ok;
        for (int i = 0; i < NUM_CH; i++)
            load[i] = (state_q == ST_APPLY) && req_ok && (int'(req_q.ch) == i);
    end

    assign locked = locked_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        frac_ce_chan #(
            .ACC_W  (ACC_W),
            .RST_NUM(DEF_NUM[i*ACC_W +: ACC_W]),
            .RST_DEN(DEF_DEN[i*ACC_W +: ACC_W])
        ) u_chan (
            .refclk(refclk),
            .rst_n (rst_n),
            .sync  (sync),
            .load  (load[i]),
            .ld_num(req_q.num),
            .ld_den(req_q.den),
`ifdef FRAC_CE_HALF_EN
            .ce_n  (ce_n[i]),
`endif
            .ce_p  (ce_p[i])
        );
    end

endmodule

// File: tb/tb_frac_ce_gen.sv
// Self-checking bench: closed-form pulse model (floor(k*num/den) steps) plus
// a countdown model of the reconfig handshake, compared every cycle.
`timescale 1ns/1ps
module tb_frac_ce_gen;
    // Three channels so an out-of-range cfg_ch is expressible on a 2-bit port.
    localparam int NCH = 3, AW = 16, LOCK = 16, CHW = 2;

    logic           refclk = 1'b0, rst_n = 1'b0, sync = 1'b0, cfg_valid = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [AW-1:0]  cfg_num = '0, cfg_den = '0;
    logic           cfg_ready, cfg_err, locked;
    logic [NCH-1:0] ce_p;
`ifdef FRAC_CE_HALF_EN
    logic [NCH-1:0] ce_n;
`endif
    int n_tests = 0, n_fail = 0;

    always #5 refclk = ~refclk;

    frac_ce_gen #(
        .NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LOCK),
        .DEF_NUM({NCH{16'd1}}), .DEF_DEN({NCH{16'd1}})
    ) dut (
        .refclk(refclk), .rst_n(rst_n), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
        .ce_p(ce_p),
`ifdef FRAC_CE_HALF_EN
        .ce_n(ce_n),
`endif
        .locked(locked)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_num[NCH], m_den[NCH], m_k[NCH];
    int     busy, rq_ch;
    longint rq_num, rq_den;
    bit     m_locked, apply_pend;
    logic [NCH-1:0] exp_p, exp_n;

    function automatic bit pulse_p(longint k, longint num, longint den);
        return ((k * num) / den) != (((k - 1) * num) / den);
    endfunction

    function automatic bit pulse_n(longint k, longint num, longint den);
        longint h = den / 2;
        if (num > h || pulse_p(k, num, den)) return 1'b0;
        return ((k * num + den - h) / den) != (((k - 1) * num + den - h) / den);
    endfunction

    function automatic bit req_good();
        return (rq_den != 0) && (rq_num <= rq_den) && (rq_ch < NCH);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_num[c] = 1; m_den[c] = 1; m_k[c] = 0;
        end
        busy = LOCK; m_locked = 0; apply_pend = 0;
        exp_p = '0; exp_n = '0;
    endtask

    task automatic model_step();
        int load_ch = -1;
        if (apply_pend) begin
            apply_pend = 0;
            if (req_good()) begin
                load_ch = rq_ch; m_locked = 0; busy = LOCK;
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) m_locked = 1;
        end else if (cfg_valid) begin
            apply_pend = 1; rq_ch = int'(cfg_ch); rq_num = cfg_num; rq_den = cfg_den;
        end
        for (int c = 0; c < NCH; c++) begin
            exp_p[c] = 1'b0; exp_n[c] = 1'b0;
            if (c == load_ch) begin
                m_num[c] = rq_num; m_den[c] = rq_den; m_k[c] = 0;
            end else if (sync) begin
                m_k[c] = 0;
            end else if (m_num[c] != 0) begin
                m_k[c]++;
                exp_p[c] = pulse_p(m_k[c], m_num[c], m_den[c]);
                exp_n[c] = pulse_n(m_k[c], m_num[c], m_den[c]);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge refclk);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            check("ce_p", ce_p, exp_p);
            check("locked", locked, m_locked);
            check("cfg_ready", cfg_ready, !apply_pend && busy == 0);
            check("cfg_err", cfg_err, apply_pend && !req_good());
`ifdef FRAC_CE_HALF_EN
            check("ce_n", ce_n, exp_n);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge refclk); #2; end
    endtask

    // Returns in the APPLY cycle; 'stalled' counts edges seen with ready low.
    task automatic cfg(input int ch, input int num, input int den, output int stalled);
        bit rdy;
        stalled = 0;
        cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_num = AW'(num); cfg_den = AW'(den);
        forever begin
            rdy = cfg_ready;
            tick();
            if (rdy) break;
            if (++stalled > 200) begin check("cfg_hs_timeout", cfg_ready, 1); break; end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!(locked && cfg_ready) && n < 100) begin tick(); n++; end
        check("lock_wait", locked, 1);
    endtask

    task automatic lock_seq(input string tag);
        for (int i = 1; i <= LOCK; i++) begin
            tick();
            check(tag, locked, i == LOCK);
        end
    endtask

    task automatic pulse_sync();
        sync = 1'b1; tick(); sync = 1'b0;
    endtask

    initial begin
        int st, cnt;
        logic prev, adj;
        logic [11:0] seq;
        int rej[3][3] = '{'{0, 5, 4}, '{0, 1, 0}, '{3, 1, 1}};

        tick(3);
        check("rst_ce_p", ce_p, 0);
        check("rst_locked", locked, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_err", cfg_err, 0);
        rst_n = 1'b1;
        lock_seq("lock_after_rst");
        check("default_ce", ce_p, 3'b111);

        // 1/4 on ch0, phase-aligned by sync
        cfg(0, 1, 4, st);
        check("t2_err", cfg_err, 0);
        wait_lock();
        pulse_sync();
        for (int i = 0; i < 12; i++) begin tick(); seq[i] = ce_p[0]; end
        check("t2_seq", seq, 12'b1000_1000_1000);

        // 358/1250: exact count per window, never adjacent
        cfg(1, 358, 1250, st);
        wait_lock();
        pulse_sync();
        prev = 1'b0; adj = 1'b0;
        for (int w = 0; w < 2; w++) begin
            cnt = 0;
            for (int i = 0; i < 1250; i++) begin
                tick();
                cnt += int'(ce_p[1]);
                adj |= prev & ce_p[1];
                prev = ce_p[1];
            end
            check("t3_count", cnt, 358);
        end
        check("t3_adjacent", adj, 0);

        // rejected requests: err pulse, lock untouched
        for (int r = 0; r < 3; r++) begin
            cfg(rej[r][0], rej[r][1], rej[r][2], st);
            check("t4_err", cfg_err, 1);
            check("t4_locked", locked, 1);
            tick();
            check("t4_err_one", cfg_err, 0);
            check("t4_ready", cfg_ready, 1);
        end

        // num = den and num = 0 boundaries
        cfg(2, 7, 7, st); wait_lock(); tick(3);
        check("t4_full", ce_p[2], 1);
        cfg(2, 0, 5, st); wait_lock(); tick(3);
        check("t4_off", ce_p[2], 0);

        // request held through SETTLE, then sync in its APPLY cycle
        cfg(0, 3, 8, st);
        cfg(1, 2, 9, st);
        check("t5_stall", st, LOCK + 1);
        pulse_sync();
        check("t5_sync_ce", ce_p, 0);
        wait_lock();

`ifdef FRAC_CE_HALF_EN
        cfg(0, 1, 8, st); wait_lock();
        pulse_sync();
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("t6_ce_p", ce_p[0], (i % 8) == 0);
            check("t6_ce_n", ce_n[0], (i % 8) == 4);
        end
`endif

        // randomized reconfigs with random sync
        for (int it = 0; it < 40; it++) begin
            cfg($urandom_range(0, 3), $urandom_range(0, 22), $urandom_range(0, 20), st);
            repeat ($urandom_range(5, 50)) begin
                sync = ($urandom_range(0, 15) == 0);
                tick();
            end
            sync = 1'b0;
        end
        wait_lock();

        // async reset in the middle of a SETTLE
        cfg(2, 5, 5, st); wait_lock();
        cfg(1, 1, 3, st);
        tick(4);
        check("t6_pre_ce", ce_p[2], 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_async_ce", ce_p, 0);
        check("t6_async_locked", locked, 0);
        check("t6_async_ready", cfg_ready, 0);
`ifdef FRAC_CE_HALF_EN
        check("t6_async_ce_n", ce_n, 0);
`endif
        tick(2);
        rst_n = 1'b1;
        lock_seq("lock_after_rst2");
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
